tpu_dma_desc_queue: RTL

- Descriptor queue and sequencer directly upstream of the TPU DMA engine.
- Accepts DMA descriptors (src, dst, len, direction, mode) from the CSR block or control core into a FIFO.
- Issues descriptors one at a time to the engine's start/argument inputs and waits for its done or error.
- Tracks completions, halts on error or timeout, and raises a sticky interrupt.

---
 rtl/tpu_dma_desc_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tpu_dma_desc_queue.sv
// tpu_dma_desc_queue: descriptor FIFO plus a single-outstanding sequencer feeding the TPU DMA engine.
// Halts on engine error or watchdog timeout until flushed; irq is sticky.
module tpu_dma_desc_queue #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [ADDR_WIDTH-1:0]   desc_src,
  input  logic [ADDR_WIDTH-1:0]   desc_dst,
  input  logic [15:0]             desc_len,
  input  logic                    desc_dir,
  input  logic [1:0]              desc_mode,
  input  logic                    desc_irq_en,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    irq_clear,
  output logic                    dma_start,
  output logic [ADDR_WIDTH-1:0]   dma_src_addr,
  output logic [ADDR_WIDTH-1:0]   dma_dst_addr,
  output logic [15:0]             dma_len,
  output logic                    dma_direction,
  output logic [1:0]              dma_mode,
  input  logic                    dma_busy,
  input  logic                    dma_done,
  input  logic                    dma_error,
  output logic [$clog2(DEPTH):0]  queue_count,
  output logic                    seq_busy,
  output logic                    halted,
  output logic                    timeout_flag,
  output logic [15:0]             completed_count,
  output logic                    irq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [15:0]           len;
    logic                  dir;
    logic [1:0]            mode;
    logic                  irq_en;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t        state_q, state_d;
  desc_t         mem_q [DEPTH];
  desc_t         arg_q, arg_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   wdog_q, wdog_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic          irq_q, irq_d, tmo_q, tmo_d;
  logic          push, pop, timeout, done_ok, irq_set;

  assign desc_ready = (count_q != CW'(DEPTH)) && !flush;
  assign push       = desc_valid && desc_ready;
  assign pop        = (state_q == S_IDLE) && (state_d == S_ISSUE);
  // Counter starts at 0 on the first S_WAIT cycle, so halt lands exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout    = (TIMEOUT_CYCLES != 0) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (enable && count_q != '0 && !dma_busy && !flush) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = dma_error ? S_HALT : dma_done ? S_IDLE : timeout ? S_HALT : S_WAIT;
      S_HALT:  state_d = flush ? S_IDLE : S_HALT;
    endcase
  end

  always_comb begin
    dma_start = state_q == S_ISSUE;
    seq_busy  = state_q != S_IDLE;
    halted    = state_q == S_HALT;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = flush ? wr_ptr_q : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    arg_d      = pop ? mem_q[rd_ptr_q] : arg_q;
    wdog_d     = (state_q == S_WAIT) ? wdog_q + 32'd1 : '0;
    done_ok    = (state_q == S_WAIT) && dma_done && !dma_error;
    done_cnt_d = done_ok ? done_cnt_q + 16'd1 : done_cnt_q;
    irq_set    = (done_ok && arg_q.irq_en) || (state_q != S_HALT && state_d == S_HALT);
    irq_d      = irq_set ? 1'b1 : irq_clear ? 1'b0 : irq_q;
    tmo_d      = (state_q == S_WAIT && state_d == S_HALT && !dma_error) ? 1'b1 :
                 (state_q == S_HALT && flush) ? 1'b0 : tmo_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arg_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wdog_q     <= '0;
      done_cnt_q <= '0;
      irq_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      arg_q      <= arg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wdog_q     <= wdog_d;
      done_cnt_q <= done_cnt_d;
      irq_q      <= irq_d;
      tmo_q      <= tmo_d;
    end

  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= '{desc_src, desc_dst, desc_len, desc_dir, desc_mode, desc_irq_en};

  assign dma_src_addr    = arg_q.src;
  assign dma_dst_addr    = arg_q.dst;
  assign dma_len         = arg_q.len;
  assign dma_direction   = arg_q.dir;
  assign dma_mode        = arg_q.mode;
  assign queue_count     = count_q;
  assign timeout_flag    = tmo_q;
  assign completed_count = done_cnt_q;
  assign irq             = irq_q;
endmodule
